// File: rtl/step_ctrl_pkg.sv
// Shared types and defaults for the run/step controller that gates the CPU clock divider.
// The state encoding is fixed so it stays stable for anyone probing it on the board.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_STEP_CYCLES     = 500_001;
    localparam int DEFAULT_STEP_CNT_W      = 16;

    // Counter width for a count of n cycles, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/step_ctrl_debounce.sv
// Two-flop synchronizer followed by a stable-level counter for one board input.
// The output level only follows the input after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module debounce
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             synced;

    assign synced = sync_q[1];
    assign level  = level_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    // Any return to the stable level restarts the count, so short glitches never commit.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else if (synced == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_q <= synced;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// Run/step controller driving the CPU clock divider enable: free-run, single step, or halt.
// Outputs are decoded from the next state and registered so they line up with the state register.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int STEP_CYCLES     = DEFAULT_STEP_CYCLES,
    parameter int STEP_CNT_W      = DEFAULT_STEP_CNT_W
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  run_sw,
    input  logic                  step_btn,
    input  logic                  halt_in,
    output logic                  enable,
    output logic                  step_active,
    output logic                  halted,
    output logic [STEP_CNT_W-1:0] step_count
);

    localparam int TIMER_W = cnt_width(STEP_CYCLES);

    logic                  run_db;
    logic                  step_db;
    logic                  step_db_q;
    logic                  step_pulse;
    state_t                state_q;
    state_t                state_d;
    logic [TIMER_W-1:0]    timer_q;
    logic [STEP_CNT_W-1:0] count_q;
    logic                  enable_q;
    logic                  step_active_q;
    logic                  halted_q;
    logic                  enable_d;
    logic                  step_active_d;
    logic                  halted_d;
    logic                  step_load;
    logic                  step_done;

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .raw    (run_sw),
        .level  (run_db)
    );

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .raw    (step_btn),
        .level  (step_db)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            step_db_q <= 1'b0;
        end else begin
            step_db_q <= step_db;
        end
    end

    assign step_pulse = step_db & ~step_db_q;
    assign step_load  = (state_q == IDLE) && !run_db && step_pulse;
    assign step_done  = (state_q == STEP) && !halt_in && (timer_q == '0);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            enable_q      <= 1'b0;
            step_active_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            enable_q      <= enable_d;
            step_active_q <= step_active_d;
            halted_q      <= halted_d;
        end
    end

    // Halt wins in RUN and STEP; presses during STEP or HALTED are dropped, not queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (run_db) begin
                    state_d = RUN;
                end else if (step_pulse) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (halt_in) begin
                    state_d = HALTED;
                end else if (!run_db) begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                if (halt_in) begin
                    state_d = HALTED;
                end else if (timer_q == '0) begin
                    state_d = IDLE;
                end
            end
            HALTED: begin
                if (!run_db) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        enable_d      = (state_d == RUN) || (state_d == STEP);
        step_active_d = (state_d == STEP);
        halted_d      = (state_d == HALTED);
    end

    // The timer counts down the enable window; a step only counts if it runs to completion.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            count_q <= '0;
        end else begin
            if (step_load) begin
                timer_q <= TIMER_W'(STEP_CYCLES - 1);
            end else if ((state_q == STEP) && !halt_in && (timer_q != '0)) begin
                timer_q <= timer_q - TIMER_W'(1);
            end
            if (step_done) begin
                count_q <= count_q + STEP_CNT_W'(1);
            end
        end
    end

    assign enable      = enable_q;
    assign step_active = step_active_q;
    assign halted      = halted_q;
    assign step_count  = count_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with short debounce/step windows and a 2-bit step counter.
// Inputs change 1 time unit after a rising edge and outputs are sampled there as well.
module tb_step_ctrl;

    logic       clk_in;
    logic       rst_n;
    logic       run_sw;
    logic       step_btn;
    logic       halt_in;
    logic       enable;
    logic       step_active;
    logic       halted;
    logic [1:0] step_count;

    int total;
    int bad;

    step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .STEP_CYCLES    (10),
        .STEP_CNT_W     (2)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .run_sw      (run_sw),
        .step_btn    (step_btn),
        .halt_in     (halt_in),
        .enable      (enable),
        .step_active (step_active),
        .halted      (halted),
        .step_count  (step_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic edges(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        run_sw   = 1'b0;
        step_btn = 1'b0;
        halt_in  = 1'b0;
        edges(3);
        rst_n = 1'b1;
        edges(1);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        run_sw   = 1'b1;
        step_btn = 1'b1;
        halt_in  = 1'b1;
        #3;
        total++;
        if ({enable, step_active, halted, step_count} !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%b want=00000", {enable, step_active, halted, step_count});
        end
        edges(12);
        total++;
        if ({enable, step_active, halted, step_count} !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL reset_held got=%b want=00000", {enable, step_active, halted, step_count});
        end
        do_reset();
    endtask

    task automatic test_step();
        logic exp_en;
        do_reset();
        step_btn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            edges(1);
            exp_en = (k >= 7) && (k <= 16);
            total++;
            if (enable !== exp_en) begin
                bad++;
                $display("[TB] FAIL step_enable k=%0d got=%b want=%b", k, enable, exp_en);
            end
            total++;
            if (step_active !== exp_en) begin
                bad++;
                $display("[TB] FAIL step_active k=%0d got=%b want=%b", k, step_active, exp_en);
            end
            if (k == 16 || k == 17) begin
                total++;
                if (step_count !== ((k == 17) ? 2'd1 : 2'd0)) begin
                    bad++;
                    $display("[TB] FAIL step_count k=%0d got=%0d want=%0d", k, step_count, (k == 17) ? 1 : 0);
                end
            end
        end
        step_btn = 1'b0;
        edges(10);
    endtask

    task automatic test_bounce();
        int on_cycles;
        do_reset();
        on_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            step_btn = ((k / 2) % 2 == 0);
            edges(1);
            if (enable) on_cycles++;
        end
        step_btn = 1'b1;
        for (int k = 0; k < 30; k++) begin
            edges(1);
            if (enable) on_cycles++;
        end
        total++;
        if (on_cycles !== 10) begin
            bad++;
            $display("[TB] FAIL bounce_enable_cycles got=%0d want=10", on_cycles);
        end
        total++;
        if (step_count !== 2'd1) begin
            bad++;
            $display("[TB] FAIL bounce_count got=%0d want=1", step_count);
        end
        step_btn = 1'b0;
        edges(10);
    endtask

    task automatic test_run_halt();
        do_reset();
        run_sw = 1'b1;
        edges(6);
        total++;
        if (enable !== 1'b0) begin
            bad++;
            $display("[TB] FAIL run_early got=%b want=0", enable);
        end
        edges(1);
        total++;
        if (enable !== 1'b1) begin
            bad++;
            $display("[TB] FAIL run_enable got=%b want=1", enable);
        end
        edges(23);
        total++;
        if ({enable, halted} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL run_before_halt got=%b want=10", {enable, halted});
        end
        halt_in = 1'b1;
        edges(1);
        total++;
        if ({enable, halted} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL halt_entry got=%b want=01", {enable, halted});
        end
        halt_in = 1'b0;
        edges(5);
        total++;
        if ({enable, halted} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL halt_hold got=%b want=01", {enable, halted});
        end
        step_btn = 1'b1;
        edges(15);
        total++;
        if ({enable, step_active, halted, step_count} !== 5'b00100) begin
            bad++;
            $display("[TB] FAIL halt_ignores_step got=%b want=00100", {enable, step_active, halted, step_count});
        end
        step_btn = 1'b0;
        edges(10);
        run_sw = 1'b0;
        edges(6);
        total++;
        if (halted !== 1'b1) begin
            bad++;
            $display("[TB] FAIL halt_release_early got=%b want=1", halted);
        end
        edges(1);
        total++;
        if ({enable, step_active, halted} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL halt_release got=%b want=000", {enable, step_active, halted});
        end
    endtask

    task automatic test_halt_mid_step();
        do_reset();
        step_btn = 1'b1;
        edges(11);
        total++;
        if ({enable, step_active} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL mid_step_active got=%b want=11", {enable, step_active});
        end
        halt_in = 1'b1;
        edges(1);
        total++;
        if ({enable, step_active, halted} !== 3'b001) begin
            bad++;
            $display("[TB] FAIL mid_step_halt got=%b want=001", {enable, step_active, halted});
        end
        halt_in = 1'b0;
        edges(1);
        total++;
        if ({enable, halted} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL mid_step_idle got=%b want=00", {enable, halted});
        end
        edges(20);
        total++;
        if ({enable, step_count} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL mid_step_count got=%b want=000", {enable, step_count});
        end
        step_btn = 1'b0;
        edges(10);
    endtask

    task automatic test_reset_mid_step();
        do_reset();
        step_btn = 1'b1;
        edges(20);
        step_btn = 1'b0;
        edges(10);
        total++;
        if (step_count !== 2'd1) begin
            bad++;
            $display("[TB] FAIL rst_step_first got=%0d want=1", step_count);
        end
        step_btn = 1'b1;
        edges(9);
        total++;
        if ({enable, step_active} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL rst_step_running got=%b want=11", {enable, step_active});
        end
        rst_n    = 1'b0;
        step_btn = 1'b0;
        #1;
        total++;
        if ({enable, step_active, step_count} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL rst_step_async got=%b want=0000", {enable, step_active, step_count});
        end
        edges(2);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            edges(1);
            total++;
            if ({enable, step_active, halted, step_count} !== 5'b00000) begin
                bad++;
                $display("[TB] FAIL rst_step_idle k=%0d got=%b want=00000", k, {enable, step_active, halted, step_count});
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_cnt;
        do_reset();
        for (int s = 1; s <= 4; s++) begin
            step_btn = 1'b1;
            edges(20);
            step_btn = 1'b0;
            edges(10);
            exp_cnt = 2'(s);
            total++;
            if (step_count !== exp_cnt) begin
                bad++;
                $display("[TB] FAIL wrap_count step=%0d got=%0d want=%0d", s, step_count, exp_cnt);
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        run_sw   = 1'b0;
        step_btn = 1'b0;
        halt_in  = 1'b0;
        test_reset();
        test_step();
        test_bounce();
        test_run_halt();
        test_halt_mid_step();
        test_reset_mid_step();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/step_ctrl.md
# step_ctrl

Run/step controller that sits directly upstream of the single-cycle CPU clock divider and drives its `enable` input. It synchronizes and debounces the board's run switch and step button, and runs a four-state FSM (IDLE, RUN, STEP, HALTED). The FSM either lets the divider free-run, gates it open for exactly one slow-clock period per button press, or freezes it when the CPU reports a halt.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required before a debounced input changes (10 ms at 100 MHz).
- `STEP_CYCLES`, 500_001: `enable` high-time per single step; equals one full divider period.
- `STEP_CNT_W`, 16: width of the step counter.

Ports:
- `clk_in`  in  1: board clock, same clock as the divider.
- `rst_n`  in  1: asynchronous, active-low reset.
- `run_sw`  in  1: raw run switch, asynchronous to `clk_in`.
- `step_btn`  in  1: raw step pushbutton, asynchronous.
- `halt_in`  in  1: CPU halt indication, synchronous to `clk_in`, level.
- `enable`  out  1: to the divider's `enable`; registered.
- `step_active`  out  1: high while in STEP.
- `halted`  out  1: high while in HALTED.
- `step_count`  out  STEP_CNT_W: number of completed steps, wraps.

## Operation
- Reset values: all outputs 0; state IDLE; debounced levels 0; synchronizer flops 0; counters 0.
- Synchronizer: 2-flop chain on `run_sw` and `step_btn`. `halt_in` is not synchronized.
- Debounce, per input:
  - Counter clears whenever the synchronized level equals the stable level.
  - Otherwise the counter increments each cycle.
  - When it reaches DEBOUNCE_CYCLES-1 while still mismatched, the stable level takes the synchronized value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- `step_pulse`: one-cycle pulse on each 0→1 transition of debounced step. There is no pulse on release.
- FSM. `halt_in` has highest priority in RUN and STEP.
  - IDLE: if run_db=1 → RUN. Else if step_pulse → STEP, loading the step timer with STEP_CYCLES-1.
  - RUN: if halt_in → HALTED. Else if run_db=0 → IDLE.
  - STEP: if halt_in → HALTED, with no step_count increment. Else if timer=0 → IDLE and step_count+1. Otherwise the timer decrements.
  - STEP ignores run_db and further step_pulses; a press during STEP is discarded, not queued.
  - HALTED: if run_db=0 → IDLE. step_pulse is ignored, so a halted CPU is released only by toggling run off.
- Output decode:
  - `enable`=1 iff the state is RUN or STEP.
  - `step_active`=1 iff STEP.
  - `halted`=1 iff HALTED.
  - All three are decoded from the next-state value and registered, so they align with the state register.
- step_count wraps from 2^STEP_CNT_W-1 to 0.
- Reset mid-step: the step is abandoned, `enable` drops immediately (asynchronously), and step_count is not incremented.

## Timing
- Raw input to debounced change: 2 + DEBOUNCE_CYCLES cycles, given a stable raw input.
- step_pulse → STEP, `enable`=1: next edge (1 cycle).
- In STEP, `enable` is high for exactly STEP_CYCLES consecutive cycles. Because the divider holds its counter while disabled, each step yields exactly one rising edge of its `clk_out`.
- step_count updates on the same edge that `enable` falls at step end.
- halt_in high on cycle N → `enable`=0 and `halted`=1 from edge N+1.
- run_db fall → `enable` low one cycle later.

## Structure
- Package `step_ctrl_pkg`:
  - State enum: IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALTED=2'b11.
  - Default constants for DEBOUNCE_CYCLES and STEP_CYCLES.
- Sub-module `debounce`: synchronizer plus stable-level counter. Parameter DEBOUNCE_CYCLES; ports `clk_in`, `rst_n`, `raw`, `level`. Instantiated twice.
- Step timer width is $clog2(STEP_CYCLES); debounce counter width is $clog2(DEBOUNCE_CYCLES).

## Test plan
Benches use DEBOUNCE_CYCLES=4, STEP_CYCLES=10.
- Step: press step_btn, hold 20 cycles → `enable` high exactly 10 cycles starting 7 cycles after the raw rise; step_count 0→1.
- Bounce: step_btn toggled every 2 cycles for 20 cycles, then held high → exactly one step, step_count=1.
- Run then halt: run_sw=1 → `enable` high after 7 cycles. Pulse halt_in on cycle 30 → `enable`=0 and `halted`=1 on cycle 31. Pressing step → no change. run_sw=0 → `halted` drops 7 cycles later, state IDLE.
- Halt mid-step: halt_in at cycle 5 of STEP → `enable` falls on the next edge, `halted`=1, step_count unchanged.
- Reset mid-step: assert rst_n=0 at cycle 3 of STEP → `enable`, `step_active` and step_count go to 0 immediately. After release, state is IDLE.
- Wrap: preload via 2^16 steps (or force STEP_CNT_W=2 and run 4 steps) → step_count wraps to 0.
